mram_dual_port_pipe: RTL
========================

// Module: mram_dual_port_pipe
// PURPOSE
//  Parametrised feature-map MRAM: port A read/write from Conv2D engine, port B read-only to next layer/system.
//  Adds configurable read latency with per-port valid pipelines and a hardware clear sweep (replaces per-entry reset).
//  Adds a defined A-write/B-read same-address collision rule. Sits between Conv2D write-back and the next-layer fetch.
// PARAMETERS
//  ADDR_WIDTH  10  address bits; depth = 2**ADDR_WIDTH
//  DATA_WIDTH  32  word width; multiple of 8; NB = DATA_WIDTH/8 byte lanes
//  RD_LATENCY  1   read latency in cycles, legal values 1 or 2
// PORTS
//  clk               in   1           clock
//  rst               in   1           asynchronous active-high reset
//  clr_req           in   1           pulse: start clear sweep (zero all entries)
//  init_busy         out  1           clear sweep in progress; both ports blocked
//  MRAM_PORTA_en     in   1           port A access enable
//  MRAM_PORTA_we     in   NB          byte write enables, bit k -> bits [8k+7:8k]
//  MRAM_PORTA_addr   in   ADDR_WIDTH  port A address
//  MRAM_PORTA_wdata  in   DATA_WIDTH  port A write data
//  MRAM_PORTA_rdata  out  DATA_WIDTH  port A read data
//  MRAM_PORTA_rvalid out  1           port A rdata valid, one-cycle pulse per accepted access
//  MRAM_PORTB_en     in   1           port B read enable
//  MRAM_PORTB_addr   in   ADDR_WIDTH  port B address
//  MRAM_PORTB_rdata  out  DATA_WIDTH  port B read data
//  MRAM_PORTB_rvalid out  1           port B rdata valid, one-cycle pulse per accepted read
// BEHAVIOUR
//  Reset (async, rst=1): rdata=0, rvalid=0, pipeline stages=0, FSM=CLEAR, clr_addr=0, init_busy=1. Array not reset.
//  FSM states:
//   - CLEAR: write 0 to entry clr_addr each cycle; clr_addr++.
//   - CLEAR exits to READY after writing entry 2**ADDR_WIDTH-1 (full sweep = 2**ADDR_WIDTH cycles).
//   - READY: clr_req=1 -> CLEAR with clr_addr=0.
//   - CLEAR: clr_req is ignored.
//  init_busy=1 exactly while FSM=CLEAR.
//  Accept rules:
//   - A accepted when MRAM_PORTA_en & !init_busy; B accepted when MRAM_PORTB_en & !init_busy.
//   - A request during busy is dropped: no write, no rvalid.
//   - A B request during busy is also dropped.
//  Port A:
//   - Accepted access writes enabled byte lanes; unmasked lanes are unchanged.
//   - Reads entry (we may be any value, including 0).
//   - Read-first on A: rdata returns the pre-write word.
//  Latency:
//   - Accept at cycle T -> rdata/rvalid at T+RD_LATENCY.
//   - Back-to-back accepts give one result per cycle.
//   - Results emerge in order.
//  rdata holds its last value when rvalid=0.
//  Collision (A write, B read, same addr, same cycle): B result defined by MRAM_FWD_EN (below).
//  Different addresses: fully independent.
//  Reset mid-operation: all in-flight results are discarded (no rvalid). The sweep restarts from 0.
//  Entry beyond depth: not possible (addr width = depth).
// CONFIGURATION
//  MRAM_FWD_EN defined:
//   - Collision B read returns merged word: new bytes on enabled lanes, old bytes elsewhere.
//   - Merged word is produced at the same latency.
//  MRAM_FWD_EN undefined:
//   - B returns the old (pre-write) word.
//   - No bypass mux is built.
// STRUCTURE
//  Package mram_pkg:
//   - FSM state enum {CLEAR, READY}.
//   - Localparams: NB, DEPTH, RD_LATENCY legality check (elaboration error if not 1/2).
//  Sub-module mram_rd_pipe:
//   - RD_LATENCY-1 stage data+valid shift pipeline.
//   - Async reset clears valid and data.
//   - Instantiated once per port.
//  Top contains the array, clear FSM, write-lane logic, collision bypass.
// TESTING
//  1. Reset, then hold rst=0 -> init_busy=1 for exactly 1024 cycles, then 0. Read addr 0, 511, 1023 on B -> 0x00000000.
//  2. A write 0xDEADBEEF @5 (we=4'hF), then A write 0x000000AA @5 (we=4'h1), then B read @5 -> 0xDEADBEAA; rvalid at T+RD_LATENCY.
//  3. Same-cycle A write 0x11223344 @7 (we=4'hF, old 0) and B read @7.
//     - With MRAM_FWD_EN: B=0x11223344.
//     - Without MRAM_FWD_EN: B=0x00000000.
//     - A rdata=0x00000000 (read-first) in both builds.
//  4. RD_LATENCY=2: B reads @0..@3 on 4 consecutive cycles -> 4 consecutive rvalid pulses, data in order, first two cycles after first accept.
//  5. clr_req while READY with data written -> init_busy=1; A/B requests during sweep produce no rvalid and no write. Afterwards all read 0.
//  6. Assert rst with 2 B reads in flight, mid-sweep -> rvalid never pulses for them. Sweep restarts, init_busy high for a full 1024 cycles.

Source files
------------

// File: rtl/mram_pkg.sv
// Shared types and default sizing for the dual-port feature-map MRAM.
package mram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } mram_state_e;

    localparam int MRAM_ADDR_WIDTH = 10;
    localparam int MRAM_DATA_WIDTH = 32;
    localparam int MRAM_NB         = MRAM_DATA_WIDTH / 8;
    localparam int MRAM_DEPTH      = 2 ** MRAM_ADDR_WIDTH;

    function automatic bit rd_latency_legal(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

endpackage

// File: rtl/mram_rd_pipe.sv
// Read-result delay line: STAGES registered data+valid stages (pass-through when STAGES is 0).
module mram_rd_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vld_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  vld_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    generate
        if (STAGES == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign vld_o  = vld_i;
            assign data_o = data_i;
        end else begin : g_pipe
            logic [STAGES-1:0]     vld_q;
            logic [DATA_WIDTH-1:0] data_q [STAGES];

            // Data only advances with its valid so the output holds between results.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= '0;
                    for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
                end else begin
                    vld_q[0] <= vld_i;
                    if (vld_i) data_q[0] <= data_i;
                    for (int i = 1; i < STAGES; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        if (vld_q[i-1]) data_q[i] <= data_q[i-1];
                    end
                end
            end

            assign vld_o  = vld_q[STAGES-1];
            assign data_o = data_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/mram_dual_port_pipe.sv
// Dual-port feature-map MRAM with clear sweep and configurable read latency.
// Define MRAM_FWD_EN to forward A write bytes into a same-address B read.
//   state | meaning
//   CLEAR | zeroing entry clr_addr_q each cycle, both ports blocked
//   READY | normal A read/write and B read traffic
module mram_dual_port_pipe
    import mram_pkg::*;
#(
    parameter int ADDR_WIDTH = MRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = MRAM_DATA_WIDTH,
    parameter int RD_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_req,
    output logic                    init_busy,
    input  logic                    MRAM_PORTA_en,
    input  logic [DATA_WIDTH/8-1:0] MRAM_PORTA_we,
    input  logic [ADDR_WIDTH-1:0]   MRAM_PORTA_addr,
    input  logic [DATA_WIDTH-1:0]   MRAM_PORTA_wdata,
    output logic [DATA_WIDTH-1:0]   MRAM_PORTA_rdata,
    output logic                    MRAM_PORTA_rvalid,
    input  logic                    MRAM_PORTB_en,
    input  logic [ADDR_WIDTH-1:0]   MRAM_PORTB_addr,
    output logic [DATA_WIDTH-1:0]   MRAM_PORTB_rdata,
    output logic                    MRAM_PORTB_rvalid
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    generate
        if (!rd_latency_legal(RD_LATENCY)) begin : g_bad_latency
            $error("mram_dual_port_pipe: RD_LATENCY must be 1 or 2");
        end
        if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
            $error("mram_dual_port_pipe: DATA_WIDTH must be a multiple of 8");
        end
    endgenerate

    mram_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  a_acc, b_acc;
    logic                  a_vld_q, b_vld_q;
    logic [DATA_WIDTH-1:0] a_rd_q, b_rd_q, b_rd_d;

    assign init_busy = (state_q == CLEAR);
    assign a_acc     = MRAM_PORTA_en & ~init_busy;
    assign b_acc     = MRAM_PORTB_en & ~init_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            CLEAR: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == {ADDR_WIDTH{1'b1}}) state_d = READY;
            end
            READY: begin
                if (clr_req) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // Storage is never reset; the sweep is the only way to zero it.
    always_ff @(posedge clk) begin
        if (init_busy) begin
            mem_q[clr_addr_q] <= '0;
        end else if (a_acc) begin
            for (int k = 0; k < NB; k++) begin
                if (MRAM_PORTA_we[k]) mem_q[MRAM_PORTA_addr][8*k +: 8] <= MRAM_PORTA_wdata[8*k +: 8];
            end
        end
    end

`ifdef MRAM_FWD_EN
    logic [DATA_WIDTH-1:0] b_fwd_mask;
    logic                  b_coll;

    always_comb begin
        b_fwd_mask = '0;
        b_coll     = a_acc & (MRAM_PORTA_addr == MRAM_PORTB_addr);
        for (int k = 0; k < NB; k++) begin
            b_fwd_mask[8*k +: 8] = {8{b_coll & MRAM_PORTA_we[k]}};
        end
        b_rd_d = (mem_q[MRAM_PORTB_addr] & ~b_fwd_mask) | (MRAM_PORTA_wdata & b_fwd_mask);
    end
`else
    assign b_rd_d = mem_q[MRAM_PORTB_addr];
`endif

    // First read stage; A sees the pre-write word because the array updates on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_vld_q <= 1'b0;
            b_vld_q <= 1'b0;
            a_rd_q  <= '0;
            b_rd_q  <= '0;
        end else begin
            a_vld_q <= a_acc;
            b_vld_q <= b_acc;
            if (a_acc) a_rd_q <= mem_q[MRAM_PORTA_addr];
            if (b_acc) b_rd_q <= b_rd_d;
        end
    end

    mram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .STAGES     (RD_LATENCY - 1)
    ) u_pipe_a (
        .clk    (clk),
        .rst    (rst),
        .vld_i  (a_vld_q),
        .data_i (a_rd_q),
        .vld_o  (MRAM_PORTA_rvalid),
        .data_o (MRAM_PORTA_rdata)
    );

    mram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .STAGES     (RD_LATENCY - 1)
    ) u_pipe_b (
        .clk    (clk),
        .rst    (rst),
        .vld_i  (b_vld_q),
        .data_i (b_rd_q),
        .vld_o  (MRAM_PORTB_rvalid),
        .data_o (MRAM_PORTB_rdata)
    );

endmodule
